// File: rtl/conv33_pkg.sv
// Shared constants for the 3x3 window stage.
// Window slots are numbered row-major: top-left 0 .. bottom-right 8.
package conv33_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W = cnt_w(DEF_IMG_W);
  localparam int ROW_W = cnt_w(DEF_IMG_H);

  localparam int WIN_TL = 0;
  localparam int WIN_TM = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MM = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BM = 7;
  localparam int WIN_BR = 8;

endpackage

// File: rtl/conv33_line_buf.sv
// One image row of pixels: combinational read, registered write.
// A write and a read at the same address see the old contents.
module conv33_line_buf
  import conv33_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // store the incoming pixel; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv33_window.sv
// Raster pixel stream to 3x3 windows ("valid" region only).
// Optional win_last output: define CONV33_WIN_LAST_EN.
module conv33_window
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  input  logic                         pix_sof,
  output logic signed [DATA_WIDTH-1:0] win_0_0,
  output logic signed [DATA_WIDTH-1:0] win_0_1,
  output logic signed [DATA_WIDTH-1:0] win_0_2,
  output logic signed [DATA_WIDTH-1:0] win_1_0,
  output logic signed [DATA_WIDTH-1:0] win_1_1,
  output logic signed [DATA_WIDTH-1:0] win_1_2,
  output logic signed [DATA_WIDTH-1:0] win_2_0,
  output logic signed [DATA_WIDTH-1:0] win_2_1,
  output logic signed [DATA_WIDTH-1:0] win_2_2,
`ifdef CONV33_WIN_LAST_EN
  output logic                         win_last,
`endif
  output logic                         win_valid
);

  localparam int CB = cnt_w(IMG_W);
  localparam int RB = cnt_w(IMG_H);
  localparam logic [CB-1:0] COL_MAX = CB'(IMG_W - 1);
  localparam logic [RB-1:0] ROW_MAX = RB'(IMG_H - 1);

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  logic [CB-1:0] col_cnt;
  logic [CB-1:0] cur_col;
  logic [RB-1:0] row_cnt;
  logic [RB-1:0] cur_row;
  logic          acc;
  logic          emit;
  logic          at_end;
  logic [DATA_WIDTH-1:0] lb1_q;
  logic [DATA_WIDTH-1:0] lb2_q;
  pix_t          sr     [9];
  pix_t          sr_nxt [9];
  pix_t          wq     [9];

  assign acc = pix_valid & ~rst;

  // sof forces the accepted pixel to (0,0) without waiting a cycle
  always_comb begin
    cur_col = col_cnt;
    cur_row = row_cnt;
    if (pix_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign emit   = acc && (cur_row >= RB'(2)) && (cur_col >= CB'(2));
  assign at_end = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

  conv33_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_WIDTH),
    .AW    (CB)
  ) u_lb1 (
    .clk     (clk),
    .we      (acc),
    .addr    (cur_col),
    .wr_data (pix_in),
    .rd_data (lb1_q)
  );

  conv33_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_WIDTH),
    .AW    (CB)
  ) u_lb2 (
    .clk     (clk),
    .we      (acc),
    .addr    (cur_col),
    .wr_data (lb1_q),
    .rd_data (lb2_q)
  );

  // raster position of the next pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_valid) begin
      if (cur_col == COL_MAX) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == ROW_MAX) ? '0 : cur_row + RB'(1);
      end else begin
        col_cnt <= cur_col + CB'(1);
        row_cnt <= cur_row;
      end
    end
  end

  // shift window left and bring in the new column, top to bottom
  always_comb begin
    sr_nxt = sr;
    for (int r = 0; r < 3; r++) begin
      sr_nxt[r*3]     = sr[r*3 + 1];
      sr_nxt[r*3 + 1] = sr[r*3 + 2];
    end
    sr_nxt[WIN_TR] = pix_t'(lb2_q);
    sr_nxt[WIN_MR] = pix_t'(lb1_q);
    sr_nxt[WIN_BR] = pix_in;
  end

  // shift register runs on every pixel, across row seams too
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '{default: '0};
    end else if (pix_valid) begin
      sr <= sr_nxt;
    end
  end

  // output copy only updates when a window is emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      wq <= '{default: '0};
    end else if (emit) begin
      wq <= sr_nxt;
    end
  end

  // one-cycle strobe per emitted window
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= emit;
    end
  end

`ifdef CONV33_WIN_LAST_EN
  // flags the bottom-right window of the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      win_last <= 1'b0;
    end else begin
      win_last <= emit & at_end;
    end
  end
`else
  logic unused_at_end;
  assign unused_at_end = at_end;
`endif

  assign win_0_0 = wq[WIN_TL];
  assign win_0_1 = wq[WIN_TM];
  assign win_0_2 = wq[WIN_TR];
  assign win_1_0 = wq[WIN_ML];
  assign win_1_1 = wq[WIN_MM];
  assign win_1_2 = wq[WIN_MR];
  assign win_2_0 = wq[WIN_BL];
  assign win_2_1 = wq[WIN_BM];
  assign win_2_2 = wq[WIN_BR];

endmodule
